// File: rtl/bin256_cnt_free_run_if.sv
// rtl/bin256_cnt_free_run_if.sv - counter control/status bundle; ce present with BIN256_CNT_CE_EN
interface bin256_cnt_free_run_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] n_conut;
    logic             max_tick;
    logic [WIDTH-1:0] q;
`ifdef BIN256_CNT_CE_EN
    logic             ce;

    modport master (output n_conut, output ce, input max_tick, input q);
    modport slave  (input n_conut, input ce, output max_tick, output q);
`else
    modport master (output n_conut, input max_tick, input q);
    modport slave  (input n_conut, output max_tick, output q);
`endif
endinterface

// File: rtl/bin256_cnt_free_run.sv
// rtl/bin256_cnt_free_run.sv - free-running counter 0..n_conut with terminal tick; optional ce via BIN256_CNT_CE_EN
module bin256_cnt_free_run #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    bin256_cnt_free_run_if.slave   bus
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             adv;

`ifdef BIN256_CNT_CE_EN
    assign adv = bus.ce;
`else
    assign adv = 1'b1;
`endif

    // >= rather than == so a terminal lowered below the count wraps immediately
    always_comb begin
        cnt_d = cnt_q;
        if (adv) begin
            if (cnt_q >= bus.n_conut) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.q        = cnt_q;
    assign bus.max_tick = (cnt_q == bus.n_conut);
endmodule

// File: tb/tb_bin256_cnt_free_run.sv
// tb/tb_bin256_cnt_free_run.sv - vector table, corner sequences and randomized model check for bin256_cnt_free_run
module tb_bin256_cnt_free_run;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    bin256_cnt_free_run_if #(.WIDTH(8)) bus ();

    bin256_cnt_free_run #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int edges;
        int exp_q;
        int exp_tick;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int m;
        int n;
        int ticks;
        int qerr;
        bus.n_conut = 8'd10;
`ifdef BIN256_CNT_CE_EN
        bus.ce = 1'b1;
`endif
        reset = 1'b1;
        #1;
        chk("reset_q", int'(bus.q), 0);
        chk("reset_tick_n10", int'(bus.max_tick), 0);
        bus.n_conut = 8'd0;
        #1;
        chk("reset_tick_n0", int'(bus.max_tick), 1);
        step(2);
        chk("reset_held_q", int'(bus.q), 0);
        reset = 1'b0;

        vecs.push_back('{10, 0, 0, 0});
        vecs.push_back('{10, 1, 1, 0});
        vecs.push_back('{10, 3, 3, 0});
        vecs.push_back('{10, 10, 10, 1});
        vecs.push_back('{10, 11, 0, 0});
        vecs.push_back('{10, 12, 1, 0});
        vecs.push_back('{255, 255, 255, 1});
        vecs.push_back('{255, 256, 0, 0});
        vecs.push_back('{0, 5, 0, 1});
        vecs.push_back('{1, 3, 1, 1});
        vecs.push_back('{7, 20, 4, 0});
        vecs.push_back('{3, 8, 0, 0});
        foreach (vecs[i]) begin
            bus.n_conut = 8'(vecs[i].n);
            pulse_reset();
            step(vecs[i].edges);
            chk($sformatf("vec%0d_q", i), int'(bus.q), vecs[i].exp_q);
            chk($sformatf("vec%0d_tick", i), int'(bus.max_tick), vecs[i].exp_tick);
        end

        // period 11: q sequence and tick count over 33 edges with n=10
        bus.n_conut = 8'd10;
        pulse_reset();
        ticks = 0;
        qerr = 0;
        for (int e = 1; e <= 33; e++) begin
            step(1);
            if (int'(bus.q) != e % 11) qerr++;
            if (bus.max_tick) ticks++;
        end
        chk("n10_seq_errors", qerr, 0);
        chk("n10_ticks_in_33", ticks, 3);

        // full 256-state run, two periods
        bus.n_conut = 8'd255;
        pulse_reset();
        ticks = 0;
        qerr = 0;
        for (int e = 1; e <= 512; e++) begin
            step(1);
            if (int'(bus.q) != e % 256) qerr++;
            if (bus.max_tick) ticks++;
        end
        chk("n255_seq_errors", qerr, 0);
        chk("n255_ticks_in_512", ticks, 2);

        // n=0 holds 0 with tick high every cycle
        bus.n_conut = 8'd0;
        pulse_reset();
        qerr = 0;
        for (int e = 0; e < 6; e++) begin
            step(1);
            if (bus.q != 8'd0 || !bus.max_tick) qerr++;
        end
        chk("n0_hold_errors", qerr, 0);

        // lower the terminal below the count at q=8
        bus.n_conut = 8'd10;
        pulse_reset();
        step(8);
        chk("lower_at_q8", int'(bus.q), 8);
        bus.n_conut = 8'd5;
        #1;
        chk("lower_no_tick", int'(bus.max_tick), 0);
        step(1);
        chk("lower_wrap_q", int'(bus.q), 0);
        step(5);
        chk("lower_q5", int'(bus.q), 5);
        chk("lower_tick_q5", int'(bus.max_tick), 1);

        // raise the terminal above the count
        step(1);
        step(3);
        chk("raise_pre_q", int'(bus.q), 3);
        bus.n_conut = 8'd20;
        step(17);
        chk("raise_q20", int'(bus.q), 20);
        chk("raise_tick", int'(bus.max_tick), 1);

        // async reset mid-cycle at q=7
        bus.n_conut = 8'd10;
        pulse_reset();
        step(7);
        chk("async_pre_q", int'(bus.q), 7);
        #2;
        reset = 1'b1;
        #1;
        chk("async_q0_before_edge", int'(bus.q), 0);
        #1;
        reset = 1'b0;
        step(1);
        chk("async_resume_1", int'(bus.q), 1);
        step(1);
        chk("async_resume_2", int'(bus.q), 2);

`ifdef BIN256_CNT_CE_EN
        bus.n_conut = 8'd10;
        pulse_reset();
        step(4);
        bus.ce = 1'b0;
        step(3);
        chk("ce_hold_q4", int'(bus.q), 4);
        bus.ce = 1'b1;
        step(1);
        chk("ce_resume_q5", int'(bus.q), 5);
        step(5);
        chk("ce_tick_shift", int'(bus.max_tick), 1);
        bus.ce = 1'b0;
        bus.n_conut = 8'd0;
        pulse_reset();
        chk("ce_reset_override", int'(bus.q), 0);
        bus.ce = 1'b1;
`endif

        // randomized run against an arithmetic reference
        n = 37;
        bus.n_conut = 8'(n);
        pulse_reset();
        m = 0;
        for (int c = 0; c < 3000; c++) begin
            bit en;
            chk("rand_q", int'(bus.q), m);
            chk("rand_tick", int'(bus.max_tick), (m == n) ? 1 : 0);
            if ($urandom_range(0, 15) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
                bus.n_conut = 8'(n);
            end
            en = 1'b1;
`ifdef BIN256_CNT_CE_EN
            en = ($urandom_range(0, 3) != 0);
            bus.ce = en;
`endif
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
                m = 0;
            end else begin
                step(1);
                if (en) m = (m >= n) ? 0 : (m + 1) % 256;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
